// File: rtl/fc_pkg.sv
// Shared definitions for the FC2 sequencer: FSM encoding and layer geometry.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_BIAS   = 3'd4,
        ST_RESULT = 3'd5
    } fc2_state_t;

    localparam int FC2_N_IN        = 84;
    localparam int FC2_N_OUT       = 10;
    localparam int FC2_MEM_LATENCY = 1;

endpackage

// File: rtl/fc2_addr_counter.sv
// Loadable up-counter for the shared read address; saturates at LAST and flags it.
module fc2_addr_counter #(
    parameter int WIDTH = 7,
    parameter int LAST  = 83
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    assign tc = (count == LAST_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fc2_sequencer.sv
// FC2 layer sequencer: streams N_IN activations into the multiplier bank and
// strobes the accumulators. Optional bias cycle enabled by defining FC2_BIAS_EN.
module fc2_sequencer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_IN       = FC2_N_IN,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] act_rdata,
    output logic [DATA_WIDTH-1:0] mult_data_in,
    output logic                  acc_clear,
    output logic                  acc_en,
    output logic                  bias_sel,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2:0]            fsm_state
);

    // Handshake: results are transferred on any rising edge where res_valid
    // and res_ready are both high; res_valid stays high until that edge.

    fc2_state_t state;
    logic       drain_last;
    logic       bias_q;
    logic       rd_en_d;
    logic       acc_pipe;
    logic       addr_tc;

    fc2_addr_counter #(
        .WIDTH (ADDR_WIDTH),
        .LAST  (N_IN - 1)
    ) u_addr (
        .clk   (clk),
        .reset (reset),
        .load  (state == ST_IDLE && start),
        .inc   (state == ST_RUN),
        .count (rd_addr),
        .tc    (addr_tc)
    );

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;
    assign bias_sel  = bias_q;
    assign acc_en    = acc_pipe | bias_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            drain_last <= 1'b0;
            bias_q     <= 1'b0;
            rd_en      <= 1'b0;
            acc_clear  <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CLEAR;
                        acc_clear <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    acc_clear <= 1'b0;
                    rd_en     <= 1'b1;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (addr_tc) begin
                        rd_en      <= 1'b0;
                        drain_last <= 1'b0;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles let the last read reach the accumulators.
                    if (drain_last) begin
`ifdef FC2_BIAS_EN
                        bias_q    <= 1'b1;
                        state     <= ST_BIAS;
`else
                        res_valid <= 1'b1;
                        state     <= ST_RESULT;
`endif
                    end else begin
                        drain_last <= 1'b1;
                    end
                end
                ST_BIAS: begin
                    bias_q    <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after rd_en; the product is accumulated one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_d      <= 1'b0;
            acc_pipe     <= 1'b0;
            mult_data_in <= '0;
        end else begin
            rd_en_d  <= rd_en;
            acc_pipe <= rd_en_d;
            if (rd_en_d) begin
                mult_data_in <= act_rdata;
            end
        end
    end

endmodule

// File: doc/fc2_sequencer.md
Name: fc2_sequencer

Overview:
- Control sequencer for the second fully connected layer (N_IN activations × 10 outputs).
- Streams one activation per cycle from the previous layer's buffer, together with the matching 10-weight row from weight memory, into the 10-lane multiplier bank.
- Drives clear/enable strobes for the external 10-lane accumulator bank.
- Presents a valid/ready result handshake to the downstream argmax stage.

Parameters:
- DATA_WIDTH, 32, width of activations, weights and products
- N_IN, 84, number of input activations per inference
- ADDR_WIDTH, 7, address width of the activation buffer and weight memory; must satisfy 2^ADDR_WIDTH >= N_IN

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin an inference; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- rd_addr  out  ADDR_WIDTH  shared read address for activation buffer and weight memory
- rd_en  out  1  read strobe; memory data valid exactly 1 cycle later
- act_rdata  in  DATA_WIDTH  activation read data
- mult_data_in  out  DATA_WIDTH  registered activation broadcast to all 10 multipliers
- acc_clear  out  1  one-cycle pulse that zeroes all 10 accumulators
- acc_en  out  1  accumulators add the current multiplier products this cycle
- bias_sel  out  1  accumulators add bias instead of product (FC2_BIAS_EN only; tied 0 otherwise)
- res_valid  out  1  the 10 accumulator values are final
- res_ready  in  1  downstream accepts the results

Behaviour:
- Reset values: state=IDLE, rd_addr=0, rd_en=0, mult_data_in=0, acc_clear=0, acc_en=0, bias_sel=0, res_valid=0, busy=0.
- FSM states: IDLE, CLEAR, RUN, DRAIN, [BIAS], RESULT.
- IDLE:
  - start=1 -> CLEAR.
  - start while busy is ignored; it is not queued.
- CLEAR:
  - acc_clear=1 for exactly 1 cycle; rd_addr=0.
  - Next state: RUN.
- RUN:
  - rd_en=1 and rd_addr=k on RUN cycle k, for k=0..N_IN-1.
  - On the cycle rd_addr=N_IN-1 -> DRAIN.
  - rd_addr never exceeds N_IN-1 and never wraps.
- Pipeline:
  - mult_data_in <= act_rdata whenever the delayed rd_en (rd_en_d) is 1.
  - acc_en = rd_en_d delayed by one more cycle (acc_en is high 2 cycles after the matching rd_en), so acc_en aligns with the registered multiplier operand.
  - acc_en is high for exactly N_IN cycles per inference.
- DRAIN:
  - Lasts 2 cycles so the final accumulate completes.
  - rd_en=0 throughout.
  - Next state: BIAS if enabled, else RESULT.
- RESULT:
  - res_valid=1 and held while res_ready=0.
  - On res_valid && res_ready -> IDLE; res_valid falls the next cycle.
  - res_ready=1 on the first RESULT cycle gives a 1-cycle RESULT.
- Latency, without bias:
  - start sampled at cycle 0.
  - First res_valid at cycle N_IN+4 (CLEAR 1 + RUN N_IN + DRAIN 2 + 1).
  - For the default N_IN=84: cycle 88.
- Reset mid-operation: returns to IDLE on the next edge and drops all strobes; the accumulators are not cleared by this block.
- rd_addr holds its last value when rd_en=0.
- Simultaneous res_ready and start in RESULT: the handshake completes and start is ignored (it was not sampled in IDLE).

Optional Feature:
- Macro: FC2_BIAS_EN.
- Defined:
  - BIAS state of 1 cycle inserted after DRAIN, with bias_sel=1 and acc_en=1.
  - res_valid first rises at cycle N_IN+5.
- Undefined:
  - No BIAS state; bias_sel is constant 0.
  - Latency N_IN+4.

Decomposition:
- Shared package fc_pkg holds:
  - FSM state encoding enum fc2_state_t (3 bits)
  - FC2_N_IN=84
  - FC2_N_OUT=10
  - FC2_MEM_LATENCY=1
- One sub-module: fc2_addr_counter, a loadable up-counter with a terminal-count flag, used for rd_addr and the RUN-to-DRAIN transition.
- The pipeline delay registers stay in the top module.

Test Plan:
- Reset then idle: hold reset 3 cycles, start=0 for 10 cycles -> all outputs 0, busy=0, no rd_en.
- Nominal run, N_IN=84, res_ready tied 1:
  - pulse start at cycle 0 -> acc_clear at cycle 1; rd_addr 0..83 on cycles 2..85.
  - acc_en high cycles 4..87 (84 cycles); res_valid for exactly one cycle at 88; busy low at 89.
  - Behavioural model with act=k+1 and weight=1 -> every lane's sum is 3570.
- Backpressure: res_ready=0 for 20 cycles after res_valid rises -> res_valid and state held, no rd_en or acc_en pulses; raise res_ready -> IDLE the next cycle.
- Start while busy: pulse start at cycles 0 and 40 -> exactly one inference; acc_clear count=1, acc_en count=84.
- Reset mid-run: assert reset at rd_addr=50 -> the next cycle rd_en=0, acc_en=0, busy=0; a new start yields a full 84-read run from address 0.
- FC2_BIAS_EN defined: nominal run -> bias_sel=1 with acc_en=1 at cycle 88 only; res_valid at cycle 89.
